fp_classify_stream: RTL

- Streaming IEEE-754 single-precision classifier: the decode side of the team's FP special-value encoding.
- Accepts 32-bit FP words on a valid/ready input, emits the word plus a one-hot 10-bit class vector on a valid/ready output.
- Keeps saturating per-class occurrence counters, readable by a select port.
- Sits in front of the FP datapath and testbenches to flag NaN/inf/subnormal operands and collect statistics.

---
 rtl/fp_classify_stream.sv | 110 +++++++++++
 1 files changed

// File: rtl/fp_classify_stream.sv
// fp_classify_stream: two-stage IEEE-754 single classifier with per-class saturating counters
module fp_classify_stream #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [31:0]      in_fp,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [31:0]      out_fp,
    output logic [9:0]       out_class,
    input  logic             cnt_clr,
    input  logic [3:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_val
);
    logic             s1_vld_q, s1_sign_q, s1_eall_q, s1_ezero_q, s1_mzero_q, s1_mmsb_q;
    logic [31:0]      s1_fp_q;
    logic             out_vld_q;
    logic [31:0]      out_fp_q;
    logic [9:0]       out_class_q, class_d;
    logic [CNT_W-1:0] cnt_q [11];
    logic [CNT_W-1:0] cnt_val_q, cnt_val_d;
    logic             s2_adv, s1_adv, out_hs;
    logic             nan, norm, sub, zero, inf;

    assign s2_adv    = !out_vld_q | out_rdy;
    assign s1_adv    = !s1_vld_q | s2_adv;
    assign in_rdy    = s1_adv;
    assign out_hs    = out_vld_q & out_rdy;
    assign out_vld   = out_vld_q;
    assign out_fp    = out_fp_q;
    assign out_class = out_class_q;
    assign cnt_val   = cnt_val_q;

    // Decode the stage-1 field flags into the one-hot class; NaNs ignore sign
    always_comb begin
        nan     = s1_eall_q & !s1_mzero_q;
        inf     = s1_eall_q & s1_mzero_q;
        zero    = s1_ezero_q & s1_mzero_q;
        sub     = s1_ezero_q & !s1_mzero_q;
        norm    = !s1_eall_q & !s1_ezero_q;
        class_d = {nan & s1_mmsb_q, nan & !s1_mmsb_q,
                   inf & !s1_sign_q, norm & !s1_sign_q, sub & !s1_sign_q, zero & !s1_sign_q,
                   zero & s1_sign_q, sub & s1_sign_q, norm & s1_sign_q, inf & s1_sign_q};
    end

    // Stage 1 captures the word and its field flags on an input handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_fp_q    <= '0;
            s1_sign_q  <= 1'b0;
            s1_eall_q  <= 1'b0;
            s1_ezero_q <= 1'b0;
            s1_mzero_q <= 1'b0;
            s1_mmsb_q  <= 1'b0;
        end else if (s1_adv) begin
            s1_vld_q <= in_vld;
            if (in_vld) begin
                s1_fp_q    <= in_fp;
                s1_sign_q  <= in_fp[31];
                s1_eall_q  <= &in_fp[30:23];
                s1_ezero_q <= ~|in_fp[30:23];
                s1_mzero_q <= ~|in_fp[22:0];
                s1_mmsb_q  <= in_fp[22];
            end
        end
    end

    // Stage 2 holds the emitted word and class; stalls while downstream is not ready
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q   <= 1'b0;
            out_fp_q    <= '0;
            out_class_q <= '0;
        end else if (s2_adv) begin
            out_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                out_fp_q    <= s1_fp_q;
                out_class_q <= class_d;
            end
        end
    end

    // Saturating per-class and total counters; clear beats a coincident handshake
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            for (int i = 0; i < 11; i++) cnt_q[i] <= '0;
        end else if (out_hs) begin
            for (int i = 0; i < 10; i++)
                if (out_class_q[i] && !(&cnt_q[i])) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            if (!(&cnt_q[10])) cnt_q[10] <= cnt_q[10] + CNT_W'(1);
        end
    end

    // Select mux for the readout; out-of-range selects read zero
    always_comb begin
        cnt_val_d = '0;
        for (int i = 0; i < 11; i++)
            if (cnt_sel == 4'(i)) cnt_val_d = cnt_q[i];
    end

    // Registered readout shows the counters as they stood before this edge
    always_ff @(posedge clk) begin
        if (rst) cnt_val_q <= '0;
        else     cnt_val_q <= cnt_val_d;
    end
endmodule
